data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 93 +++++++++
 tb/tb_data_memory.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Brief    : Single-port-per-direction word memory with a zeroing INIT sweep,
//            write-first read forwarding and a sticky dropped-request flag.
// Revision : 1.0
// ============================================================================
module data_memory #(
    parameter int WORD_SIZE_P = 16,
    parameter int ELS_P       = 256
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   data_mem_w_v_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_w_addr_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_w_data_i,
    input  logic                   data_mem_r_v_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_r_addr_i,
    output logic [WORD_SIZE_P-1:0] data_mem_r_data_o,
    output logic                   mem_ready_o,
    output logic                   mem_drop_o
);

    localparam int IDX_W = $clog2(ELS_P);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELS_P - 1);

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_idx;
    logic             in_ready;
    logic             same_idx;

    logic [WORD_SIZE_P-1:0] mem [ELS_P];

    // Upper address bits are dropped by the cast, so accesses alias modulo ELS_P.
    assign w_idx    = IDX_W'(data_mem_w_addr_i);
    assign r_idx    = IDX_W'(data_mem_r_addr_i);
    assign in_ready = (state == READY);
    assign same_idx = (w_idx == r_idx);

    always_comb begin
        state_next = state;
        if (state == INIT && init_cnt == LAST_IDX) begin
            state_next = READY;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state             <= INIT;
            init_cnt          <= '0;
            data_mem_r_data_o <= '0;
            mem_drop_o        <= 1'b0;
        end else begin
            state <= state_next;
            if (!in_ready) begin
                init_cnt <= init_cnt + 1'b1;
                if (data_mem_w_v_i || data_mem_r_v_i) begin
                    mem_drop_o <= 1'b1;
                end
            end else if (data_mem_r_v_i) begin
                // Write-first: a colliding write is forwarded to the read port.
                if (data_mem_w_v_i && same_idx) begin
                    data_mem_r_data_o <= data_mem_w_data_i;
                end else begin
                    data_mem_r_data_o <= mem[r_idx];
                end
            end
        end
    end

    // Array carries no reset; the INIT sweep establishes its contents.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (!in_ready) begin
                mem[init_cnt] <= '0;
            end else if (data_mem_w_v_i) begin
                mem[w_idx] <= data_mem_w_data_i;
            end
        end
    end

    assign mem_ready_o = in_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Brief    : Directed plus random checks of data_memory against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_data_memory;

    localparam int W   = 16;
    localparam int ELS = 256;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         w_v;
    logic [W-1:0] w_addr;
    logic [W-1:0] w_data;
    logic         r_v;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_data;
    logic         ready;
    logic         drop;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since reset decide INIT vs READY.
    int           cyc;
    logic [W-1:0] mem_m [ELS];
    logic [W-1:0] rdata_m;
    logic         drop_m;

    data_memory #(.WORD_SIZE_P(W), .ELS_P(ELS)) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .data_mem_w_v_i    (w_v),
        .data_mem_w_addr_i (w_addr),
        .data_mem_w_data_i (w_data),
        .data_mem_r_v_i    (r_v),
        .data_mem_r_addr_i (r_addr),
        .data_mem_r_data_o (r_data),
        .mem_ready_o       (ready),
        .mem_drop_o        (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("ready", {15'd0, ready}, {15'd0, (cyc >= ELS)});
        chk("drop",  {15'd0, drop},  {15'd0, drop_m});
        chk("rdata", r_data, rdata_m);
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input logic wv, input logic [W-1:0] wa, input logic [W-1:0] wd,
                        input logic rv, input logic [W-1:0] ra);
        w_v = wv; w_addr = wa; w_data = wd; r_v = rv; r_addr = ra;
        @(posedge clk);
        if (cyc < ELS) begin
            if (wv || rv) drop_m = 1'b1;
            mem_m[cyc] = '0;
            cyc++;
        end else begin
            if (rv) rdata_m = (wv && (wa % ELS) == (ra % ELS)) ? wd : mem_m[ra % ELS];
            if (wv) mem_m[wa % ELS] = wd;
        end
        #1;
        chk_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Reset pulse placed between clock edges so its asynchronous effect is visible.
    task automatic do_reset();
        #1;
        reset_i = 1'b0;
        w_v = 1'b0; r_v = 1'b0;
        #1;
        cyc = 0; rdata_m = '0; drop_m = 1'b0;
        chk("rst_rdata", r_data, 16'h0000);
        chk("rst_ready", {15'd0, ready}, 16'h0000);
        chk("rst_drop",  {15'd0, drop},  16'h0000);
        @(posedge clk);
        #3;
        reset_i = 1'b1;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset_i = 1'b0;
        w_v = 1'b0; w_addr = '0; w_data = '0; r_v = 1'b0; r_addr = '0;
        cyc = 0; rdata_m = '0; drop_m = 1'b0;
        @(posedge clk);
        #2;
        chk("por_rdata", r_data, 16'h0000);
        chk("por_ready", {15'd0, ready}, 16'h0000);
        #1;
        reset_i = 1'b1;

        // Ready must rise on exactly the 256th edge after release.
        idle(ELS - 1);
        chk("ready_255", {15'd0, ready}, 16'h0000);
        idle(1);
        chk("ready_256", {15'd0, ready}, 16'h0001);
        step(1'b0, '0, '0, 1'b1, 16'h00FF);
        chk("rd_00ff", r_data, 16'h0000);

        step(1'b1, 16'h0010, 16'h1234, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 16'h0010);
        chk("rd_0010", r_data, 16'h1234);

        step(1'b1, 16'h0020, 16'hBEEF, 1'b1, 16'h0020);
        chk("wf_0020", r_data, 16'hBEEF);
        step(1'b0, '0, '0, 1'b1, 16'h0120);
        chk("alias_0120", r_data, 16'hBEEF);

        // Different-index write and read in the same cycle.
        step(1'b1, 16'h0030, 16'h0C0C, 1'b1, 16'h0010);
        chk("diff_rd", r_data, 16'h1234);
        step(1'b0, '0, '0, 1'b1, 16'h0030);
        chk("diff_wr", r_data, 16'h0C0C);

        // Request during INIT is dropped and flagged.
        do_reset();
        step(1'b1, 16'h0005, 16'hAAAA, 1'b0, '0);
        chk("drop_set", {15'd0, drop}, 16'h0001);
        idle(ELS - 1);
        chk("drop_sticky", {15'd0, drop}, 16'h0001);
        step(1'b0, '0, '0, 1'b1, 16'h0005);
        chk("rd_5_zero", r_data, 16'h0000);

        // Reset mid-READY re-zeroes the array.
        step(1'b1, 16'h0007, 16'h5555, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 16'h0007);
        chk("rd_7", r_data, 16'h5555);
        do_reset();
        idle(ELS);
        step(1'b0, '0, '0, 1'b1, 16'h0007);
        chk("rd_7_zero", r_data, 16'h0000);

        // Streamed reads with gaps: 1-cycle latency and hold across gaps.
        for (int i = 0; i < 16; i++) step(1'b1, W'(i), W'($urandom), 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, '0, 1'b1, W'(i));
            if (i % 3 == 2) idle(1 + (i % 2));
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            a = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 7));
            b = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), a, W'($urandom), 1'($urandom_range(0, 1)), b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
